// File: rtl/history_predictor_ckpt_pkg.sv
// Shared types and helpers for the checkpointed global-history predictor.
package predictor_pkg;

   localparam int unsigned HASH_CONCAT = 0;
   localparam int unsigned HASH_XOR    = 1;

   // Checkpoint fields are sized for the widest supported configuration;
   // instances zero-extend into them and slice back out.
   localparam int unsigned CKPT_IDX_MAX = 16;
   localparam int unsigned CKPT_CNT_MAX = 8;
   localparam int unsigned CKPT_HR_MAX  = 16;

   typedef enum logic {
      INIT,
      RUN
   } state_e;

   typedef struct packed {
      logic [CKPT_IDX_MAX-1:0] index;
      logic [CKPT_CNT_MAX-1:0] count;
      logic [CKPT_HR_MAX-1:0]  hr;
   } ckpt_t;

   // Table index from PC and history; the result is already masked to idx_w bits.
   function automatic logic [31:0] hash_index(input logic [31:0] pc,
                                              input logic [31:0] hr,
                                              input int unsigned idx_w,
                                              input int unsigned hr_w,
                                              input int unsigned mode);
      logic [31:0] pcw;
      logic [31:0] idx_mask;
      logic [31:0] hr_mask;
      logic [31:0] res;
      pcw      = pc >> 2;
      idx_mask = (32'd1 << idx_w) - 32'd1;
      hr_mask  = (32'd1 << hr_w) - 32'd1;
      if (mode == HASH_CONCAT) begin
         res = (pcw << hr_w) | (hr & hr_mask);
      end else if (mode == HASH_XOR) begin
         res = pcw ^ (hr & hr_mask);
      end else begin
         res = '0;
      end
      return res & idx_mask;
   endfunction

   // Saturating up/down step of a cnt_w-bit counter.
   function automatic logic [CKPT_CNT_MAX-1:0] sat_update(input logic [CKPT_CNT_MAX-1:0] count,
                                                          input logic                    dir,
                                                          input int unsigned             cnt_w);
      logic [CKPT_CNT_MAX-1:0] top;
      logic [CKPT_CNT_MAX-1:0] res;
      top = CKPT_CNT_MAX'((32'd1 << cnt_w) - 32'd1);
      res = count;
      if (dir) begin
         if (count != top) res = count + CKPT_CNT_MAX'(1);
      end else begin
         if (count != '0) res = count - CKPT_CNT_MAX'(1);
      end
      return res;
   endfunction

endpackage

// File: rtl/history_predictor_ckpt_counter_table.sv
// Jump-status counter table: one combinational read port, one synchronous write port.
module counter_table #(
   parameter int unsigned INDEX_WIDTH = 10,
   parameter int unsigned CNT_WIDTH   = 2
) (
   input  logic                   clk_i,
   input  logic [INDEX_WIDTH-1:0] raddr_i,
   output logic [CNT_WIDTH-1:0]   rdata_o,
   input  logic                   we_i,
   input  logic [INDEX_WIDTH-1:0] waddr_i,
   input  logic [CNT_WIDTH-1:0]   wdata_i
);

   logic [CNT_WIDTH-1:0] mem_q [2**INDEX_WIDTH];

   // Read returns the pre-write contents when read and write hit the same entry.
   assign rdata_o = mem_q[raddr_i];

   // Single write port; contents are cleared by the parent's init sweep, not by reset.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

endmodule

// File: rtl/history_predictor_ckpt.sv
// Global-history branch predictor with a checkpoint queue of in-flight
// predictions, in-order training, history recovery and a power-up table sweep.
module history_predictor_ckpt
   import predictor_pkg::*;
#(
   parameter  int unsigned CNT_WIDTH   = 2,
   parameter  int unsigned CNT_INIT    = 1,
   parameter  int unsigned INDEX_WIDTH = 10,
   parameter  int unsigned HR_WIDTH    = 6,
   parameter  int unsigned HASH_MODE   = 0,
   parameter  int unsigned CKPT_DEPTH  = 4,
   localparam int unsigned OCC_W       = $clog2(CKPT_DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 PL_stall,
   input  logic                 lookup_en,
   input  logic [31:0]          pc,
   output logic [CNT_WIDTH-1:0] pred_count,
   output logic                 pred_taken,
   output logic                 lookup_ack,
   input  logic                 resolve_en,
   input  logic                 resolve_taken,
   input  logic                 flush_en,
   output logic                 ready,
   output logic                 full,
   output logic [OCC_W-1:0]     occupancy,
   output logic                 mispredict,
   output logic                 err_underflow
);

   localparam int unsigned PTR_W = $clog2(CKPT_DEPTH);

   state_e                 state_q, state_d;
   logic [INDEX_WIDTH-1:0] sweep_q, sweep_d;
   logic [HR_WIDTH-1:0]    spec_hr_q, spec_hr_d;
   logic [HR_WIDTH-1:0]    arch_hr_q, arch_hr_d;
   logic [PTR_W-1:0]       head_q, head_d;
   logic [PTR_W-1:0]       tail_q, tail_d;
   logic [OCC_W-1:0]       occ_q, occ_d;
   logic                   full_q, full_d;
   logic                   err_q, err_d;
   ckpt_t                  queue_q [CKPT_DEPTH];

   logic [31:0]             hash_full;
   logic [INDEX_WIDTH-1:0]  rd_idx;
   logic [CNT_WIDTH-1:0]    rd_cnt;
   ckpt_t                   head_e;
   ckpt_t                   push_e;
   logic [INDEX_WIDTH-1:0]  head_idx;
   logic                    head_taken;
   logic [CKPT_CNT_MAX-1:0] upd_full;
   logic                    occ_nz;
   logic                    resolve_ok;
   logic                    flush_ok;
   logic                    tbl_we;
   logic [INDEX_WIDTH-1:0]  tbl_waddr;
   logic [CNT_WIDTH-1:0]    tbl_wdata;
   logic                    unused_bits;

   assign hash_full = hash_index(pc, 32'(spec_hr_q), INDEX_WIDTH, HR_WIDTH, HASH_MODE);
   assign rd_idx    = hash_full[INDEX_WIDTH-1:0];

   counter_table #(
      .INDEX_WIDTH(INDEX_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_table (
      .clk_i  (clk),
      .raddr_i(rd_idx),
      .rdata_o(rd_cnt),
      .we_i   (tbl_we),
      .waddr_i(tbl_waddr),
      .wdata_i(tbl_wdata)
   );

   assign pred_count = rd_cnt;
   assign pred_taken = rd_cnt[CNT_WIDTH-1];

   assign head_e     = queue_q[head_q];
   assign head_idx   = head_e.index[INDEX_WIDTH-1:0];
   assign head_taken = head_e.count[CNT_WIDTH-1];
   assign upd_full   = sat_update(head_e.count, resolve_taken, CNT_WIDTH);

   assign ready      = (state_q == RUN);
   assign occ_nz     = (occ_q != '0);
   assign resolve_ok = ready & resolve_en & occ_nz;
   assign flush_ok   = ready & flush_en;
   assign mispredict = resolve_ok & (head_taken != resolve_taken);
   assign lookup_ack = ready & lookup_en & ~PL_stall & ~full_q & ~mispredict & ~flush_en;

   assign full          = full_q;
   assign occupancy     = occ_q;
   assign err_underflow = err_q;

   // Upper checkpoint/hash bits beyond the configured widths are always zero.
   assign unused_bits = ^{hash_full, upd_full, head_e};

   // Checkpoint record pushed at the tail on an accepted lookup.
   always_comb begin
      push_e                        = '0;
      push_e.index[INDEX_WIDTH-1:0] = rd_idx;
      push_e.count[CNT_WIDTH-1:0]   = rd_cnt;
      push_e.hr[HR_WIDTH-1:0]       = spec_hr_q;
   end

   // Next-state: init sweep, then lookup/resolve/flush bookkeeping.
   always_comb begin
      state_d   = state_q;
      sweep_d   = sweep_q;
      spec_hr_d = spec_hr_q;
      arch_hr_d = arch_hr_q;
      head_d    = head_q;
      tail_d    = tail_q;
      occ_d     = occ_q;
      err_d     = err_q;
      tbl_we    = 1'b0;
      tbl_waddr = head_idx;
      tbl_wdata = upd_full[CNT_WIDTH-1:0];
      case (state_q)
         INIT: begin
            tbl_we    = 1'b1;
            tbl_waddr = sweep_q;
            tbl_wdata = CNT_WIDTH'(CNT_INIT);
            sweep_d   = sweep_q + INDEX_WIDTH'(1);
            if (sweep_q == '1) state_d = RUN;
         end
         RUN: begin
            if (resolve_ok) begin
               tbl_we    = 1'b1;
               arch_hr_d = {arch_hr_q[HR_WIDTH-2:0], resolve_taken};
               head_d    = head_q + PTR_W'(1);
            end
            if (resolve_en && !occ_nz) err_d = 1'b1;
            if (lookup_ack) begin
               tail_d    = tail_q + PTR_W'(1);
               spec_hr_d = {spec_hr_q[HR_WIDTH-2:0], pred_taken};
            end
            occ_d = occ_q + OCC_W'(lookup_ack) - OCC_W'(resolve_ok);
            // Squash restores speculative history from the post-resolve architectural value.
            if (mispredict || flush_ok) begin
               head_d    = '0;
               tail_d    = '0;
               occ_d     = '0;
               spec_hr_d = arch_hr_d;
            end
         end
         default: state_d = INIT;
      endcase
      full_d = (occ_d == OCC_W'(CKPT_DEPTH));
   end

   // State register with synchronous reset; reset restarts the sweep.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= INIT;
         sweep_q   <= '0;
         spec_hr_q <= '0;
         arch_hr_q <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         occ_q     <= '0;
         full_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sweep_q   <= sweep_d;
         spec_hr_q <= spec_hr_d;
         arch_hr_q <= arch_hr_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         occ_q     <= occ_d;
         full_q    <= full_d;
         err_q     <= err_d;
      end
   end

   // Checkpoint storage; validity is tracked by the pointers and occupancy.
   always_ff @(posedge clk) begin
      if (lookup_ack) queue_q[tail_q] <= push_e;
   end

endmodule

// File: doc/history_predictor_ckpt.md
Name: history_predictor_ckpt

Overview:
Global-history branch predictor with parametrised index hashing, a checkpoint queue of in-flight predictions, and a power-up table-clear sweep. It is the successor to the fixed ID/EX-rollback predictor. It sits beside fetch: it predicts at lookup, records each speculative prediction, trains the counter table when the branch resolves in order, and restores history on mispredict or flush. It supports an arbitrary number of in-flight branches, not just two pipeline stages.

Parameters:
CNT_WIDTH, 2, width of each saturating jump-status counter.
CNT_INIT, 1, counter value written by the init sweep. MSB set means predict taken.
INDEX_WIDTH, 10, table index width. The table has 2^INDEX_WIDTH entries.
HR_WIDTH, 6, global history register width. Must satisfy HR_WIDTH < INDEX_WIDTH.
HASH_MODE, 0, 0 = concat {pc[INDEX_WIDTH-HR_WIDTH+1:2], hr}; 1 = xor pc[INDEX_WIDTH+1:2] ^ zero-extended hr.
CKPT_DEPTH, 4, maximum number of unresolved predictions. Must be a power of two and at least 2.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
PL_stall  in  1  pipeline stall; gates lookup pushes only
lookup_en  in  1  a branch is fetched this cycle
pc  in  32  PC of the fetched branch
pred_count  out  CNT_WIDTH  counter read at hash(pc, spec_hr); combinational
pred_taken  out  1  pred_count MSB; combinational
lookup_ack  out  1  lookup accepted and checkpointed this cycle; combinational
resolve_en  in  1  the oldest in-flight branch resolves
resolve_taken  in  1  actual outcome of that branch
flush_en  in  1  external squash of all in-flight branches (exception, redirect)
ready  out  1  init sweep done; lookups allowed
full  out  1  occupancy == CKPT_DEPTH
occupancy  out  $clog2(CKPT_DEPTH+1)  number of queued checkpoints
mispredict  out  1  the resolving entry's prediction != resolve_taken; combinational
err_underflow  out  1  sticky; set by resolve_en while the queue is empty

Behaviour:
- Reset: clk-synchronous, sampled when rst=1.
  - FSM to INIT, sweep pointer = 0, spec_hr = arch_hr = 0, queue emptied.
  - ready=0, full=0, occupancy=0, err_underflow=0.
  - Asserting reset mid-sweep or mid-run restarts the sweep from entry 0.
- FSM INIT:
  - Writes CNT_INIT to entry[ptr] each cycle; ptr increments.
  - After the entry 2^INDEX_WIDTH-1 write, goes to RUN. ready=1 from the next cycle, i.e. exactly 2^INDEX_WIDTH cycles after reset deasserts.
  - In INIT, lookup_en, resolve_en and flush_en are ignored; lookup_ack=0 and mispredict=0.
- FSM RUN: INIT is re-entered only via rst.
- Lookup accept: lookup_ack = ready & lookup_en & !PL_stall & !full & !(resolve_en & mispredict) & !flush_en.
  - On accept, push {index, pred_count, spec_hr} at the tail.
  - spec_hr <= {spec_hr[HR_WIDTH-2:0], pred_taken}.
  - A rejected lookup changes no state; the predict outputs are still driven.
- Resolve, when ready and occupancy > 0: pop the head entry.
  - Write the table at the stored index with a saturating update: +1 if taken, -1 if not; clamp at all-ones and at 0.
  - arch_hr <= {arch_hr[HR_WIDTH-2:0], resolve_taken}.
  - mispredict = (stored count MSB != resolve_taken).
  - On mispredict: the queue is cleared (younger entries squashed) and spec_hr <= the new arch_hr value, so the last bit is resolve_taken.
- Resolve with occupancy == 0: no table write, no history change; err_underflow <= 1.
- flush_en:
  - Queue cleared; spec_hr <= arch_hr, using the value after any same-cycle resolve.
  - A same-cycle resolve still trains the table and arch_hr.
- Same-cycle lookup and resolve without mispredict:
  - Both happen. Occupancy is unchanged.
  - full is evaluated on the pre-cycle occupancy, so a lookup while full is rejected even with a concurrent pop.
- Same-cycle resolve write and lookup read of the same index: the read returns the old (pre-write) value.
- Queue: circular buffer with head/tail pointers of $clog2(CKPT_DEPTH) bits that wrap. occupancy is a separate counter. full and occupancy are registered.
- Counter arithmetic is CNT_WIDTH-bit with no wrap. Indices are truncated to INDEX_WIDTH.

Decomposition:
- Package predictor_pkg:
  - HASH_CONCAT/HASH_XOR constants.
  - hash_index function (pc, hr, mode).
  - sat_update function (count, dir).
  - FSM state enum {INIT, RUN}.
  - checkpoint struct {index, count, hr}.
- One sub-module: counter_table.
  - 2^INDEX_WIDTH x CNT_WIDTH register array.
  - One combinational read port and one synchronous write port.
  - The write mux between sweep and resolve lives in the parent.

Test Plan:
- Init: pulse rst 1 cycle, defaults. ready rises exactly 1024 cycles later; lookups at pc=0x0,0x400,0xFFC all give pred_count=1, pred_taken=0. Reasserting rst at cycle 500 restarts the count to 1024.
- Training: pc=0x100, 3x (lookup, resolve_taken=1) gives pred_count 1,2,3; a 4th resolve stays at 3. Then 4x not-taken gives 2,1,0,0. The first resolve asserts mispredict=1.
- Queue full: 4 accepted lookups with no resolve give full=1, occupancy=4. A 5th lookup gets lookup_ack=0 and spec_hr is unchanged. A same-cycle lookup + non-mispredicting resolve at full gives occupancy 3 next cycle.
- Mispredict recovery: with arch_hr=6'b000000, 3 not-taken predictions outstanding, the oldest resolves taken. Result: mispredict=1, occupancy=0, spec_hr=arch_hr=6'b000001. A same-cycle lookup gets ack=0.
- Flush: 2 outstanding plus flush_en and a concurrent correct resolve give occupancy 0, spec_hr = updated arch_hr, and the table entry still trained.
- HASH_MODE=1, pc=0x3C, hr=6'b101010 gives index 10'h00F ^ 10'h02A = 10'h025. resolve_en while empty sets err_underflow=1, held until rst.
